regfile_mp: RTL and testbench
=============================

REGFILE_MP -- requirements
Module: regfile_mp

Interface
REQ-001 SHALL have parameter DataW, default 32, meaning register data width in bits.
REQ-002 SHALL have parameter NumRegs, default 32, meaning number of architectural registers (power of two, >=2); AddrW = log2(NumRegs).
REQ-003 SHALL have parameter NumRd, default 2, meaning number of core read ports (1..4).
REQ-004 SHALL have parameter NumWr, default 2, meaning number of core write ports (1..4).
REQ-005 SHALL have parameter MaxWait, default 15, meaning debug-wait cycles before dbg_hold_o asserts (1..255).
REQ-006 SHALL have ports: clk_i  in  1  clock; single clock domain, all logic on rising edge.
REQ-007 SHALL have ports: rst_i  in  1  reset; synchronous, active-high.
REQ-008 SHALL have ports: we_i  in  NumWr  per-port core write enable; waddr_i  in  NumWr x AddrW  write address; wdata_i  in  NumWr x DataW  write data.
REQ-009 SHALL have ports: raddr_i  in  NumRd x AddrW  read address; rdata_o  out  NumRd x DataW  read data.
REQ-010 SHALL have ports: rsv_i  in  1  reserve request; rsv_addr_i  in  AddrW  register to mark busy; busy_o  out  NumRegs  per-register pending-write flags.
REQ-011 SHALL have ports: dbg_req_i  in  1  debug access request; dbg_we_i  in  1  1=write 0=read; dbg_addr_i  in  AddrW; dbg_wdata_i  in  DataW.
REQ-012 SHALL have ports: dbg_gnt_o  out  1  one-cycle access done; dbg_rdata_o  out  DataW  read result, valid with dbg_gnt_o; dbg_hold_o  out  1  request to core to stop writing.

Function
REQ-013 Register 0 SHALL read as 0 on every port and SHALL ignore all writes and reservations.
REQ-014 Core writes SHALL commit on the rising edge where we_i[k]=1; if several ports target the same address, the highest index k SHALL win.
REQ-015 Reads SHALL be combinational: rdata_o[j] = data of highest-index active write port with matching nonzero address (bypass), else stored value.
REQ-016 busy_o[r] SHALL set one cycle after rsv_i=1 with rsv_addr_i=r, and SHALL clear one cycle after any core write to r.
REQ-017 Simultaneous reserve and write of the same register SHALL leave busy_o[r]=1 (reserve wins).
REQ-018 Debug FSM SHALL have states IDLE, WAIT, DONE.
REQ-019 IDLE: on dbg_req_i=1 SHALL go to WAIT, latching dbg_we_i, dbg_addr_i, dbg_wdata_i; wait counter cleared.
REQ-020 WAIT: in any cycle with all we_i=0, the access SHALL execute (write commits on that edge; read samples stored value) and FSM SHALL go to DONE.
REQ-021 WAIT: otherwise counter SHALL increment (saturating); dbg_hold_o SHALL be 1 while in WAIT with counter >= MaxWait.
REQ-022 DONE: dbg_gnt_o=1 and dbg_rdata_o valid for exactly one cycle; FSM SHALL return to IDLE; dbg_hold_o=0.
REQ-023 Debug write to register 0 SHALL complete the handshake without changing state; debug read of register 0 SHALL return 0.
REQ-024 Debug writes SHALL NOT affect busy_o; a debug write SHALL be visible to core reads on the following cycle (no bypass).
REQ-025 dbg_req_i changes after leaving IDLE SHALL be ignored until the FSM returns to IDLE; a new request SHALL be accepted no earlier than the cycle after DONE.
REQ-026 dbg_rdata_o SHALL hold its last value outside DONE.

Reset
REQ-027 While rst_i=1 at a clock edge: all registers SHALL become 0, busy_o=0, FSM=IDLE, counter=0, dbg_gnt_o=0, dbg_hold_o=0, dbg_rdata_o=0.
REQ-028 Reset mid-debug-access SHALL abandon it with no write and no grant; core writes in the reset cycle SHALL be discarded.

Verification
REQ-029 Write x5=0xDEADBEEF on port 0 and x5=0x12345678 on port 1 same cycle, read x5 same cycle and next -> both 0x12345678.
REQ-030 rsv x7, then write x7 two cycles later while rsv x7 same cycle -> busy_o[7] stays 1; a later write alone clears it next cycle.
REQ-031 Debug write x3=0xA5A5A5A5 with we_i idle -> dbg_gnt_o pulses 2 cycles after request; core read of x3 next cycle returns 0xA5A5A5A5.
REQ-032 Debug read with we_i continuously busy, MaxWait=15 -> dbg_hold_o rises after 15 WAIT cycles; on first idle cycle grant follows with correct data, hold drops.
REQ-033 Write x0=0xFFFFFFFF on all ports, debug write x0, rsv x0 -> all reads of x0 return 0, busy_o[0]=0, grant still issued.
REQ-034 Assert rst_i during WAIT -> no dbg_gnt_o, all registers 0, busy_o=0; fresh request after reset completes normally.

Source files
------------

// File: rtl/regfile_mp.sv
// Multi-ported register file with write bypass, per-register pending-write flags,
// and a debug access port that waits for a cycle with no core writes.
module regfile_mp #(
   parameter  int DataW   = 32,
   parameter  int NumRegs = 32,
   parameter  int NumRd   = 2,
   parameter  int NumWr   = 2,
   parameter  int MaxWait = 15,
   localparam int AddrW   = $clog2(NumRegs)
) (
   input  logic                         clk_i,
   input  logic                         rst_i,
   input  logic [NumWr-1:0]             we_i,
   input  logic [NumWr-1:0][AddrW-1:0]  waddr_i,
   input  logic [NumWr-1:0][DataW-1:0]  wdata_i,
   input  logic [NumRd-1:0][AddrW-1:0]  raddr_i,
   output logic [NumRd-1:0][DataW-1:0]  rdata_o,
   input  logic                         rsv_i,
   input  logic [AddrW-1:0]             rsv_addr_i,
   output logic [NumRegs-1:0]           busy_o,
   input  logic                         dbg_req_i,
   input  logic                         dbg_we_i,
   input  logic [AddrW-1:0]             dbg_addr_i,
   input  logic [DataW-1:0]             dbg_wdata_i,
   output logic                         dbg_gnt_o,
   output logic [DataW-1:0]             dbg_rdata_o,
   output logic                         dbg_hold_o
);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} dbg_state_t;

   localparam logic [7:0] MaxWaitC = 8'(MaxWait);

   dbg_state_t         state_reg;
   logic [7:0]         wait_cnt_reg;
   logic [7:0]         wait_cnt_next;
   logic               dbg_we_reg;
   logic [AddrW-1:0]   dbg_addr_reg;
   logic [DataW-1:0]   dbg_wdata_reg;
   logic [DataW-1:0]   dbg_rdata_reg;
   logic               gnt_reg;
   logic               hold_reg;
   logic               core_idle;
   logic               dbg_fire;
   logic [DataW-1:0]   regs [NumRegs];

   assign core_idle     = ~|we_i;
   // The debug access only executes in a cycle where no core port writes.
   assign dbg_fire      = (state_reg == WAIT) && core_idle;
   assign wait_cnt_next = (wait_cnt_reg == 8'hFF) ? wait_cnt_reg : wait_cnt_reg + 8'd1;

   genvar gi;
   generate
      for (gi = 0; gi < NumRegs; gi++) begin : g_reg
         if (gi == 0) begin : g_zero
            assign regs[gi]   = '0;
            assign busy_o[gi] = 1'b0;
         end else begin : g_live
            logic [DataW-1:0] data_reg;
            logic [DataW-1:0] data_next;
            logic             busy_reg;
            logic             wr_hit;

            always_comb begin
               data_next = data_reg;
               wr_hit    = 1'b0;
               for (int k = 0; k < NumWr; k++) begin
                  if (we_i[k] && waddr_i[k] == AddrW'(gi)) begin
                     data_next = wdata_i[k];
                     wr_hit    = 1'b1;
                  end
               end
               if (dbg_fire && dbg_we_reg && dbg_addr_reg == AddrW'(gi))
                  data_next = dbg_wdata_reg;
            end

            always_ff @(posedge clk_i) begin
               if (rst_i) begin
                  data_reg <= '0;
                  busy_reg <= 1'b0;
               end else begin
                  data_reg <= data_next;
                  // A reservation in the same cycle as a write keeps the flag set.
                  busy_reg <= (rsv_i && rsv_addr_i == AddrW'(gi)) || (busy_reg && !wr_hit);
               end
            end

            assign regs[gi]   = data_reg;
            assign busy_o[gi] = busy_reg;
         end
      end

      for (gi = 0; gi < NumRd; gi++) begin : g_rd
         logic [DataW-1:0] rd;
         always_comb begin
            rd = regs[raddr_i[gi]];
            for (int k = 0; k < NumWr; k++) begin
               if (we_i[k] && waddr_i[k] == raddr_i[gi])
                  rd = wdata_i[k];
            end
            if (raddr_i[gi] == '0)
               rd = '0;
         end
         assign rdata_o[gi] = rd;
      end
   endgenerate

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_reg     <= IDLE;
         wait_cnt_reg  <= '0;
         dbg_we_reg    <= 1'b0;
         dbg_addr_reg  <= '0;
         dbg_wdata_reg <= '0;
         dbg_rdata_reg <= '0;
         gnt_reg       <= 1'b0;
         hold_reg      <= 1'b0;
      end else begin
         gnt_reg  <= 1'b0;
         hold_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (dbg_req_i) begin
                  state_reg     <= WAIT;
                  dbg_we_reg    <= dbg_we_i;
                  dbg_addr_reg  <= dbg_addr_i;
                  dbg_wdata_reg <= dbg_wdata_i;
                  wait_cnt_reg  <= '0;
               end
            end
            WAIT: begin
               if (core_idle) begin
                  state_reg <= DONE;
                  gnt_reg   <= 1'b1;
                  if (!dbg_we_reg)
                     dbg_rdata_reg <= regs[dbg_addr_reg];
               end else begin
                  wait_cnt_reg <= wait_cnt_next;
                  hold_reg     <= (wait_cnt_next >= MaxWaitC);
               end
            end
            DONE:    state_reg <= IDLE;
            default: state_reg <= IDLE;
         endcase
      end
   end

   assign dbg_gnt_o   = gnt_reg;
   assign dbg_rdata_o = dbg_rdata_reg;
   assign dbg_hold_o  = hold_reg;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized and directed bench for regfile_mp, checked against an array-based
// reference model of the architectural state and busy flags.
module tb_regfile_mp;
   localparam int DataW = 32, NumRegs = 32, NumRd = 2, NumWr = 2, MaxWait = 15;
   localparam int AddrW = $clog2(NumRegs);

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic [NumWr-1:0]            we;
   logic [NumWr-1:0][AddrW-1:0] waddr;
   logic [NumWr-1:0][DataW-1:0] wdata;
   logic [NumRd-1:0][AddrW-1:0] raddr;
   logic [NumRd-1:0][DataW-1:0] rdata;
   logic                        rsv;
   logic [AddrW-1:0]            rsv_addr;
   logic [NumRegs-1:0]          busy;
   logic                        dbg_req, dbg_we, dbg_gnt, dbg_hold;
   logic [AddrW-1:0]            dbg_addr;
   logic [DataW-1:0]            dbg_wdata, dbg_rdata;

   logic [DataW-1:0]   m_mem [NumRegs];
   logic [NumRegs-1:0] m_busy;
   int n_cmp = 0;
   int n_bad = 0;

   regfile_mp #(.DataW(DataW), .NumRegs(NumRegs), .NumRd(NumRd), .NumWr(NumWr), .MaxWait(MaxWait)) dut (
      .clk_i(clk), .rst_i(rst), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
      .raddr_i(raddr), .rdata_o(rdata), .rsv_i(rsv), .rsv_addr_i(rsv_addr), .busy_o(busy),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
      .dbg_gnt_o(dbg_gnt), .dbg_rdata_o(dbg_rdata), .dbg_hold_o(dbg_hold)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   // Expected combinational read: last-index same-cycle writer wins, x0 is always 0.
   function automatic logic [DataW-1:0] exp_read(input logic [AddrW-1:0] a);
      logic [DataW-1:0] v;
      if (a == 0) return '0;
      v = m_mem[a];
      for (int k = 0; k < NumWr; k++)
         if (we[k] && waddr[k] == a) v = wdata[k];
      return v;
   endfunction

   task automatic idle_inputs();
      we = '0; waddr = '0; wdata = '0; rsv = 1'b0; rsv_addr = '0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = '0; dbg_wdata = '0;
   endtask

   // Advance one clock, applying the current inputs to the model first.
   task automatic step();
      if (rst) begin
         for (int r = 0; r < NumRegs; r++) m_mem[r] = '0;
         m_busy = '0;
      end else begin
         for (int k = 0; k < NumWr; k++)
            if (we[k] && waddr[k] != 0) begin
               m_mem[waddr[k]] = wdata[k];
               m_busy[waddr[k]] = 1'b0;
            end
         if (rsv && rsv_addr != 0) m_busy[rsv_addr] = 1'b1;
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle_inputs(); raddr = '0; rst = 1'b1;
      step(); step();
      rst = 1'b0;
      n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL reset_busy got=%h want=0", busy); end
      n_cmp++; if (dbg_gnt !== 1'b0 || dbg_hold !== 1'b0) begin n_bad++; $display("FAIL reset_dbg gnt=%b hold=%b want 0/0", dbg_gnt, dbg_hold); end
      n_cmp++; if (dbg_rdata !== '0) begin n_bad++; $display("FAIL reset_rdata got=%h want=0", dbg_rdata); end
      for (int r = 0; r < NumRegs; r += 2) begin
         raddr[0] = AddrW'(r); raddr[1] = AddrW'(r + 1); #1;
         n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL reset_regs x%0d got=%h want=0", r, rdata); end
      end
      $display("reset: done");
   endtask

   task automatic test_same_addr();
      idle_inputs();
      we = 2'b11; waddr[0] = 5; waddr[1] = 5; wdata[0] = 32'hDEADBEEF; wdata[1] = 32'h12345678;
      raddr[0] = 5; #1;
      n_cmp++; if (rdata[0] !== 32'h12345678) begin n_bad++; $display("FAIL same_addr_bypass got=%h want=12345678", rdata[0]); end
      step(); we = '0; #1;
      n_cmp++; if (rdata[0] !== 32'h12345678) begin n_bad++; $display("FAIL same_addr_stored got=%h want=12345678", rdata[0]); end
      $display("same_addr: x5=%h", rdata[0]);
   endtask

   task automatic test_busy();
      idle_inputs();
      rsv = 1'b1; rsv_addr = 7; step(); rsv = 1'b0;
      n_cmp++; if (busy[7] !== 1'b1) begin n_bad++; $display("FAIL busy_set got=%b want=1", busy[7]); end
      step();
      we[0] = 1'b1; waddr[0] = 7; wdata[0] = 32'h0BADF00D; rsv = 1'b1; rsv_addr = 7; step();
      n_cmp++; if (busy[7] !== 1'b1) begin n_bad++; $display("FAIL busy_rsv_wins got=%b want=1", busy[7]); end
      rsv = 1'b0; waddr[0] = 7; wdata[0] = 32'h600DF00D; step(); we = '0;
      n_cmp++; if (busy[7] !== 1'b0) begin n_bad++; $display("FAIL busy_clear got=%b want=0", busy[7]); end
      n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL busy_vector got=%h want=%h", busy, m_busy); end
      $display("busy: x7 flag sequence done");
   endtask

   task automatic test_dbg_write();
      idle_inputs();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 3; dbg_wdata = 32'hA5A5A5A5;
      step(); dbg_req = 1'b0; dbg_addr = 9; dbg_wdata = '1;
      n_cmp++; if (dbg_gnt !== 1'b0) begin n_bad++; $display("FAIL dbgw_early_gnt got=%b want=0", dbg_gnt); end
      step(); m_mem[3] = 32'hA5A5A5A5;
      raddr[1] = 3; #1;
      n_cmp++; if (dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL dbgw_gnt got=%b want=1", dbg_gnt); end
      n_cmp++; if (rdata[1] !== 32'hA5A5A5A5) begin n_bad++; $display("FAIL dbgw_read got=%h want=a5a5a5a5", rdata[1]); end
      n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL dbgw_busy got=%h want=%h", busy, m_busy); end
      step();
      n_cmp++; if (dbg_gnt !== 1'b0) begin n_bad++; $display("FAIL dbgw_gnt_pulse got=%b want=0", dbg_gnt); end
      $display("dbg_write: x3=%h", rdata[1]);
   endtask

   task automatic test_dbg_hold();
      logic [DataW-1:0] exp;
      idle_inputs();
      we[0] = 1'b1; waddr[0] = 9; wdata[0] = $urandom | 32'h1; step(); we = '0;
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 9; step(); dbg_req = 1'b0;
      for (int i = 1; i <= MaxWait + 3; i++) begin
         we[0] = 1'b1; waddr[0] = AddrW'($urandom_range(1, NumRegs - 1)); wdata[0] = $urandom;
         step();
         n_cmp++; if (dbg_hold !== (i >= MaxWait)) begin n_bad++; $display("FAIL hold_cycle%0d got=%b want=%b", i, dbg_hold, i >= MaxWait); end
         n_cmp++; if (dbg_gnt !== 1'b0) begin n_bad++; $display("FAIL hold_no_gnt%0d got=%b want=0", i, dbg_gnt); end
      end
      we = '0; exp = m_mem[9]; step();
      n_cmp++; if (dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL hold_gnt got=%b want=1", dbg_gnt); end
      n_cmp++; if (dbg_rdata !== exp) begin n_bad++; $display("FAIL hold_rdata got=%h want=%h", dbg_rdata, exp); end
      n_cmp++; if (dbg_hold !== 1'b0) begin n_bad++; $display("FAIL hold_drop got=%b want=0", dbg_hold); end
      step();
      n_cmp++; if (dbg_rdata !== exp) begin n_bad++; $display("FAIL hold_rdata_keep got=%h want=%h", dbg_rdata, exp); end
      $display("dbg_hold: read x9=%h after wait", dbg_rdata);
   endtask

   task automatic test_reg0();
      idle_inputs();
      we = 2'b11; waddr = '0; wdata[0] = '1; wdata[1] = '1; rsv = 1'b1; rsv_addr = 0; raddr = '0;
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 0; dbg_wdata = '1; #1;
      n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL reg0_bypass got=%h want=0", rdata); end
      step(); idle_inputs(); raddr = '0;
      n_cmp++; if (busy[0] !== 1'b0) begin n_bad++; $display("FAIL reg0_busy got=%b want=0", busy[0]); end
      step();
      n_cmp++; if (dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL reg0_dbg_gnt got=%b want=1", dbg_gnt); end
      step();
      n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL reg0_read got=%h want=0", rdata); end
      dbg_req = 1'b1; dbg_we = 1'b0; dbg_addr = 0; step(); dbg_req = 1'b0; step();
      n_cmp++; if (dbg_gnt !== 1'b1 || dbg_rdata !== '0) begin n_bad++; $display("FAIL reg0_dbg_read gnt=%b data=%h want 1/0", dbg_gnt, dbg_rdata); end
      step();
      $display("reg0: writes and reservation ignored");
   endtask

   task automatic test_reset_mid_wait();
      idle_inputs();
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4; dbg_wdata = 32'h55;
      we[0] = 1'b1; waddr[0] = 6; wdata[0] = 32'h66; rsv = 1'b1; rsv_addr = 6;
      step(); dbg_req = 1'b0; rsv = 1'b0; step();
      rst = 1'b1; waddr[0] = 8; wdata[0] = 32'h88; step(); rst = 1'b0; idle_inputs();
      for (int i = 0; i < 3; i++) begin
         n_cmp++; if (dbg_gnt !== 1'b0) begin n_bad++; $display("FAIL rstwait_no_gnt%0d got=%b want=0", i, dbg_gnt); end
         step();
      end
      n_cmp++; if (busy !== '0) begin n_bad++; $display("FAIL rstwait_busy got=%h want=0", busy); end
      for (int r = 0; r < NumRegs; r += 2) begin
         raddr[0] = AddrW'(r); raddr[1] = AddrW'(r + 1); #1;
         n_cmp++; if (rdata !== '0) begin n_bad++; $display("FAIL rstwait_regs x%0d got=%h want=0", r, rdata); end
      end
      dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 4; dbg_wdata = 32'h77; step(); dbg_req = 1'b0; step();
      m_mem[4] = 32'h77; raddr[0] = 4; #1;
      n_cmp++; if (dbg_gnt !== 1'b1) begin n_bad++; $display("FAIL rstwait_fresh_gnt got=%b want=1", dbg_gnt); end
      n_cmp++; if (rdata[0] !== 32'h77) begin n_bad++; $display("FAIL rstwait_fresh_data got=%h want=77", rdata[0]); end
      step();
      $display("reset_mid_wait: access abandoned, fresh access ok");
   endtask

   task automatic test_random();
      logic [DataW-1:0] exp;
      idle_inputs();
      for (int c = 0; c < 300; c++) begin
         for (int k = 0; k < NumWr; k++) begin
            we[k] = ($urandom_range(0, 2) != 0);
            waddr[k] = AddrW'($urandom_range(0, 7));
            wdata[k] = $urandom;
         end
         for (int j = 0; j < NumRd; j++) raddr[j] = AddrW'($urandom_range(0, 7));
         rsv = $urandom_range(0, 1); rsv_addr = AddrW'($urandom_range(0, 7));
         #1;
         for (int j = 0; j < NumRd; j++) begin
            exp = exp_read(raddr[j]);
            n_cmp++; if (rdata[j] !== exp) begin n_bad++; $display("FAIL rand_read c%0d p%0d x%0d got=%h want=%h", c, j, raddr[j], rdata[j], exp); end
         end
         step();
         n_cmp++; if (busy !== m_busy) begin n_bad++; $display("FAIL rand_busy c%0d got=%h want=%h", c, busy, m_busy); end
      end
      idle_inputs();
      $display("random: 300 cycles");
   endtask

   initial begin
      idle_inputs(); raddr = '0; m_busy = '0;
      for (int r = 0; r < NumRegs; r++) m_mem[r] = '0;
      test_reset();
      test_same_addr();
      test_busy();
      test_dbg_write();
      test_dbg_hold();
      test_reg0();
      test_reset_mid_wait();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
